// File: rtl/my_ram_n_pkg.sv
// Shared constants and FSM state type for the my_ram_n word store.
// Default geometry lives here so the top, interface and bench agree.
package my_ram_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/my_ram_n_if.sv
// Bus bundle for my_ram_n: write data, address, write enable, read data, busy.
// The master drives the request side; the RAM (slave) drives out and busy.
interface my_ram_n_if #(
    parameter int WIDTH  = my_ram_pkg::DEF_WIDTH,
    parameter int ADDR_W = $clog2(my_ram_pkg::DEF_DEPTH)
);
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] addr;
    logic              load;
    logic [WIDTH-1:0]  out;
    logic              busy;

    modport master (output in, addr, load, input out, busy);
    modport slave  (input in, addr, load, output out, busy);
endinterface

// File: rtl/my_register_n.sv
// WIDTH-bit storage word with a load enable; one instance per RAM word.
// No reset: contents are zeroed by the owning RAM's clear sequence.
module my_register_n #(
    parameter int WIDTH = my_ram_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/my_ram_n.sv
// DEPTH x WIDTH register-file RAM that zeroes itself word by word after reset.
// Define MY_RAM_N_BYPASS_EN for write-through reads; default is read-before-write.
module my_ram_n
    import my_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    my_ram_n_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;

    logic [DEPTH-1:0]  w_wr_en;
    logic [WIDTH-1:0]  w_wr_data;
    logic [WIDTH-1:0]  w_word [DEPTH];
    logic [WIDTH-1:0]  w_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                r_state <= READY;
                r_busy  <= 1'b0;
            end
        end
    end

    // While clearing, the pointer owns the decode and user writes are dropped;
    // a reset edge suppresses every write so a simultaneous user store is lost.
    assign w_wr_data = r_busy ? '0 : bus.in;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_wr_en[gi] = !reset &&
                (r_busy ? (r_clr_ptr == ADDR_W'(gi))
                        : (bus.load && (bus.addr == ADDR_W'(gi))));

            my_register_n #(.WIDTH(WIDTH)) u_word (
                .clk    (clk),
                .i_load (w_wr_en[gi]),
                .i_d    (w_wr_data),
                .o_q    (w_word[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data = w_word[bus.addr];
`ifdef MY_RAM_N_BYPASS_EN
        if (bus.load) begin
            w_rd_data = bus.in;
        end
`else
`endif
    end

    assign bus.out  = r_busy ? '0 : w_rd_data;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_my_ram_n.sv
// Directed + randomized bench for my_ram_n: an 8x16 instance checked against an
// array model, plus a 32x8 instance for fill/readback and clear length.
module tb_my_ram_n;
    import my_ram_pkg::*;

    localparam int W1 = 16;
    localparam int D1 = 8;
    localparam int A1 = $clog2(D1);
    localparam int W2 = 8;
    localparam int D2 = 32;
    localparam int A2 = $clog2(D2);
`ifdef MY_RAM_N_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset1;
    logic reset2;

    my_ram_n_if #(.WIDTH(W1), .ADDR_W(A1)) bus1 ();
    my_ram_n_if #(.WIDTH(W2), .ADDR_W(A2)) bus2 ();

    my_ram_n #(.WIDTH(W1), .DEPTH(D1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
    my_ram_n #(.WIDTH(W2), .DEPTH(D2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

    int tests = 0;
    int fails = 0;
    logic [W1-1:0] mem1 [D1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One READY-state cycle on dut1: drive, check combinational read, then update the model.
    task automatic op1(input logic l, input logic [A1-1:0] a, input logic [W1-1:0] d,
                       input string tag);
        logic [W1-1:0] exp;
        @(negedge clk);
        bus1.load = l;
        bus1.addr = a;
        bus1.in   = d;
        #1;
        exp = (BYPASS && l) ? d : mem1[a];
        check(tag, 32'(bus1.out), 32'(exp));
        check({tag, "_busy"}, 32'(bus1.busy), 32'd0);
        @(posedge clk);
        if (l) mem1[a] = d;
    endtask

    // Called just after reset1 drops (at a falling edge): counts busy cycles, checks out=0.
    task automatic count_busy1(input string tag);
        int n;
        n = 0;
        #1;
        while (bus1.busy === 1'b1 && n < 1000) begin
            check({tag, "_out0"}, 32'(bus1.out), 32'd0);
            n++;
            @(negedge clk);
            #1;
        end
        bus1.load = 1'b0;
        check({tag, "_len"}, 32'(n), 32'(D1));
        for (int i = 0; i < D1; i++) mem1[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset1    = 1'b1;
        reset2    = 1'b1;
        bus1.load = 1'b0;
        bus1.addr = '0;
        bus1.in   = '0;
        bus2.load = 1'b0;
        bus2.addr = '0;
        bus2.in   = '0;

        // Reset, with a write to addr 5 attempted throughout the clear.
        @(negedge clk);
        bus1.load = 1'b1;
        bus1.addr = 3'd5;
        bus1.in   = 16'h1234;
        @(negedge clk);
        reset1 = 1'b0;
        count_busy1("clear");
        op1(1'b0, 3'd5, 16'h0, "rd5_after_busy_write");

        op1(1'b1, 3'd3, 16'hBEEF, "wr3_beef");
        op1(1'b0, 3'd3, 16'h0, "rd3_beef");
        op1(1'b0, 3'd2, 16'h0, "rd2_zero");

        op1(1'b1, 3'd1, 16'h0001, "wr1_0001");
        op1(1'b1, 3'd1, 16'h00FF, "wr1_00ff_rdw");
        op1(1'b0, 3'd1, 16'h0, "rd1_00ff");

        for (int k = 0; k < 150; k++) begin
            op1(1'($urandom_range(0, 1)), A1'($urandom), W1'($urandom), "rand");
        end

        // Restart the clear partway through; addr 7 must end up zero.
        op1(1'b1, 3'd7, 16'hAAAA, "wr7_aaaa");
        @(negedge clk);
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        count_busy1("restart");
        op1(1'b0, 3'd7, 16'h0, "rd7_zero");
        op1(1'b0, 3'd3, 16'h0, "rd3_zero");

        for (int k = 0; k < 40; k++) begin
            op1(1'($urandom_range(0, 1)), A1'($urandom), W1'($urandom), "rand2");
        end

        // 32x8 instance: clear length then fill and read back.
        begin
            int n;
            @(negedge clk);
            reset2 = 1'b1;
            @(negedge clk);
            reset2 = 1'b0;
            n = 0;
            #1;
            while (bus2.busy === 1'b1 && n < 1000) begin
                check("d32_out0", 32'(bus2.out), 32'd0);
                n++;
                @(negedge clk);
                #1;
            end
            check("d32_len", 32'(n), 32'(D2));
            for (int i = 0; i < D2; i++) begin
                @(negedge clk);
                bus2.load = 1'b1;
                bus2.addr = A2'(i);
                bus2.in   = W2'(i);
            end
            @(negedge clk);
            bus2.load = 1'b0;
            for (int i = D2 - 1; i >= 0; i--) begin
                @(negedge clk);
                bus2.addr = A2'(i);
                #1;
                check("d32_rd", 32'(bus2.out), 32'(i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
